// File: rtl/sram_pkg.sv
// Shared definitions for the 8x8 scratch SRAM: default geometry, the data
// word type and the even-parity helper used on both write and read paths.
package sram_pkg;

    localparam int SRAM_DATA_W = 8;
    localparam int SRAM_ADDR_W = 3;
    localparam int DEPTH       = 1 << SRAM_ADDR_W;

    typedef logic [SRAM_DATA_W-1:0] word_t;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic parity_f(input word_t w);
        return ^w;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Storage array for the scratch SRAM: synchronous write, synchronous clear
// of every word on reset, and an unregistered read port. The read register
// and write-first bypass live in the wrapper.
module sram_array
    import sram_pkg::*;
#(
    parameter int WIDTH  = SRAM_DATA_W,
    parameter int ADDR_W = SRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    localparam int WORDS = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [WORDS];

    // Clear every word on reset, otherwise store the write data.
    // NOTE: this array is small and must read back zero after reset, so it is
    // built from flops and cleared in the reset branch; a large RAM macro
    // could not be reset this way and would need an explicit clear sequence.
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together and simulation order cannot leak into the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Every address is populated, so the read needs no range check.
    assign rdata = mem[addr];

endmodule

// File: rtl/sram.sv
// Single-port 8x8 scratch SRAM with a registered read output and write-first
// behaviour when WE and RD are asserted together.
// Optional feature: define SRAM_PARITY_EN to store an even-parity bit per word
// and report read-time mismatches on parity_err.
module sram
    import sram_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W,
    parameter int ADDR_W = SRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] dataIn,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              WE,
    input  logic              RD,
    output logic [DATA_W-1:0] dataOut
`ifdef SRAM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

`ifdef SRAM_PARITY_EN
    localparam int STORE_W = DATA_W + 1;
`else
    localparam int STORE_W = DATA_W;
`endif

    logic [STORE_W-1:0] wr_word;
    logic [STORE_W-1:0] rd_word;
    logic [DATA_W-1:0]  rd_data;
    logic [DATA_W-1:0]  next_out;

`ifdef SRAM_PARITY_EN
    logic rd_parity_bad;
`endif

    // Build the stored word: data, plus its parity bit when parity is enabled.
    // NOTE: every combinational output gets a default at the top of the block
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_word = '0;
        wr_word[DATA_W-1:0] = dataIn;
`ifdef SRAM_PARITY_EN
        wr_word[DATA_W] = parity_f(dataIn);
`endif
    end

    sram_array #(
        .WIDTH  (STORE_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (WE),
        .addr  (Addr),
        .wdata (wr_word),
        .rdata (rd_word)
    );

    // Split the stored word and pick the read source: new data on a
    // same-cycle write wins over the old stored word.
    always_comb begin
        rd_data  = rd_word[DATA_W-1:0];
        next_out = WE ? dataIn : rd_data;
`ifdef SRAM_PARITY_EN
        rd_parity_bad = (parity_f(rd_data) != rd_word[DATA_W]);
`endif
    end

    // Read register: cleared on reset, loaded on RD, held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dataOut <= '0;
`ifdef SRAM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (RD) begin
            dataOut <= next_out;
`ifdef SRAM_PARITY_EN
            // Bypassed data is freshly encoded and cannot mismatch.
            parity_err <= WE ? 1'b0 : rd_parity_bad;
`endif
        end
    end

endmodule

// File: tb/tb_sram.sv
// Self-checking bench for the scratch SRAM: a table of directed per-cycle
// vectors plus hand-written reset-mid-access and parity-corruption sequences.
module tb_sram;

    logic       clk;
    logic       rst_n;
    logic [7:0] dataIn;
    logic [2:0] Addr;
    logic       WE;
    logic       RD;
    logic [7:0] dataOut;
`ifdef SRAM_PARITY_EN
    logic       parity_err;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    sram dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dataIn     (dataIn),
        .Addr       (Addr),
        .WE         (WE),
        .RD         (RD),
        .dataOut    (dataOut)
`ifdef SRAM_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic       rd;
        logic [2:0] addr;
        logic [7:0] din;
        logic [7:0] exp_out;
        logic       exp_perr;
    } vec_t;

    vec_t vecs [64];
    int   nvec = 0;

    function automatic void add(input logic we, input logic rd,
                                input logic [2:0] addr, input logic [7:0] din,
                                input logic [7:0] exp_out);
        vecs[nvec].we       = we;
        vecs[nvec].rd       = rd;
        vecs[nvec].addr     = addr;
        vecs[nvec].din      = din;
        vecs[nvec].exp_out  = exp_out;
        vecs[nvec].exp_perr = 1'b0;
        nvec++;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, sample 1 ns later.
    task automatic step(input logic rstn, input logic we, input logic rd,
                        input logic [2:0] addr, input logic [7:0] din);
        rst_n  = rstn;
        WE     = we;
        RD     = rd;
        Addr   = addr;
        dataIn = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        WE     = 1'b0;
        RD     = 1'b0;
        Addr   = '0;
        dataIn = '0;

        // Reset held for two edges, with a write attempt that must be dropped.
        @(negedge clk);
        step(1'b0, 1'b1, 1'b1, 3'd4, 8'hEE);
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        check("reset_dataOut", dataOut, 8'h00);
`ifdef SRAM_PARITY_EN
        check("reset_parity_err", {7'd0, parity_err}, 8'h00);
`endif

        // Vector table.
        for (int i = 0; i < 8; i++) add(1'b0, 1'b1, 3'(i), 8'h00, 8'h00);   // all zero after reset
        add(1'b1, 1'b0, 3'd0, 8'hFF, 8'h00);                                 // write FF to 0
        add(1'b0, 1'b1, 3'd0, 8'h00, 8'hFF);                                 // read back FF
        add(1'b1, 1'b0, 3'd0, 8'h55, 8'hFF);                                 // RD=0: hold FF
        add(1'b0, 1'b0, 3'd6, 8'h12, 8'hFF);                                 // idle: hold FF
        add(1'b0, 1'b1, 3'd0, 8'h00, 8'h55);                                 // read 55
        for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 3'(i), 8'(8'h10 + i), 8'h55);
        for (int i = 7; i >= 0; i--) add(1'b0, 1'b1, 3'(i), 8'h00, 8'(8'h10 + i));
        add(1'b1, 1'b0, 3'd3, 8'hAA, 8'h10);                                 // mem[3]=AA
        add(1'b0, 1'b1, 3'd3, 8'h00, 8'hAA);
        add(1'b1, 1'b1, 3'd3, 8'h3C, 8'h3C);                                 // write-first
        add(1'b0, 1'b1, 3'd5, 8'h00, 8'h15);
        add(1'b0, 1'b1, 3'd3, 8'h00, 8'h3C);                                 // new data stuck

        for (int i = 0; i < nvec; i++) begin
            step(1'b1, vecs[i].we, vecs[i].rd, vecs[i].addr, vecs[i].din);
            check($sformatf("vec%0d_dataOut", i), dataOut, vecs[i].exp_out);
`ifdef SRAM_PARITY_EN
            check($sformatf("vec%0d_parity_err", i), {7'd0, parity_err}, {7'd0, vecs[i].exp_perr});
`endif
        end

        // Reset coincident with a write to address 2: write dropped, memory cleared.
        step(1'b0, 1'b1, 1'b0, 3'd2, 8'h99);
        check("midreset_dataOut", dataOut, 8'h00);
        step(1'b1, 1'b0, 1'b1, 3'd2, 8'h00);
        check("midreset_read2", dataOut, 8'h00);
        step(1'b1, 1'b0, 1'b1, 3'd3, 8'h00);
        check("midreset_read3", dataOut, 8'h00);
        step(1'b1, 1'b0, 1'b1, 3'd7, 8'h00);
        check("midreset_read7", dataOut, 8'h00);

`ifdef SRAM_PARITY_EN
        // Clean word reads without error; a flipped stored bit is flagged.
        step(1'b1, 1'b1, 1'b0, 3'd1, 8'h0F);
        step(1'b1, 1'b0, 1'b1, 3'd1, 8'h00);
        check("parity_clean_data", dataOut, 8'h0F);
        check("parity_clean_err", {7'd0, parity_err}, 8'h00);
        dut.u_array.mem[1][0] = ~dut.u_array.mem[1][0];
        step(1'b1, 1'b0, 1'b1, 3'd1, 8'h00);
        check("parity_flip_data", dataOut, 8'h0E);
        check("parity_flip_err", {7'd0, parity_err}, 8'h01);
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        check("parity_flip_hold", {7'd0, parity_err}, 8'h01);
        step(1'b1, 1'b0, 1'b1, 3'd4, 8'h00);
        check("parity_other_err", {7'd0, parity_err}, 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
